// File: rtl/skintone_ellipse_pipe.sv
// Six-stage elliptical skin-tone classifier for {Y,Cr,Cb,x} pixels with a global stall
// enable, graded-score or binary-mask output, and a running skin-pixel counter.
module skintone_ellipse_pipe #(
  parameter int FRAC_W = 9,
  parameter int CX     = 109,
  parameter int CY     = 152,
  parameter int COS_Q  = 511,
  parameter int SIN_Q  = 22,
  parameter int ECX    = 2,
  parameter int ECY    = 2,
  parameter int INV_A2 = 407,
  parameter int INV_B2 = 1332,
  parameter int MODE   = 0,
  parameter int THRESH = 256,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             datain_valid,
  input  logic [31:0]      datain,
  output logic             datain_ready,
  output logic             dataout_valid,
  output logic [31:0]      dataout,
  input  logic             dataout_ready,
  input  logic             count_clr,
  output logic [CNT_W-1:0] skin_count
);

  localparam int CW  = FRAC_W + 2;
  localparam int PW  = 9 + CW;
  localparam int SW  = PW + 1;
  localparam int XW  = SW - FRAC_W;
  localparam int EW  = XW + 1;
  localparam int SQW = 2 * EW;
  localparam int IW  = 2 * FRAC_W;
  localparam int QW  = SQW + IW + 1;
  localparam int DFW = QW - FRAC_W;
  localparam int DW  = FRAC_W + 2;
  localparam int PRW = DW + 8;

  localparam logic [7:0]            L_CX     = 8'(CX);
  localparam logic [7:0]            L_CY     = 8'(CY);
  localparam logic signed [CW-1:0]  L_COS    = CW'(COS_Q);
  localparam logic signed [CW-1:0]  L_SIN    = CW'(SIN_Q);
  localparam logic signed [EW-1:0]  L_ECX    = EW'(ECX);
  localparam logic signed [EW-1:0]  L_ECY    = EW'(ECY);
  localparam logic [IW-1:0]         L_INV_A2 = IW'(INV_A2);
  localparam logic [IW-1:0]         L_INV_B2 = IW'(INV_B2);
  localparam logic [DFW-1:0]        L_DMAX_W = DFW'((1 << DW) - 1);
  localparam logic [DW-1:0]         L_ONE    = DW'(1 << FRAC_W);
  localparam logic [31:0]           L_THRESH = 32'(THRESH);

  logic                  w_en;
  logic                  w_unused;
  logic signed [8:0]     w_dx, w_dy;
  logic signed [PW-1:0]  w_p1, w_p2, w_p3, w_p4;
  logic signed [SW-1:0]  w_sum_x, w_sum_y;
  logic signed [XW-1:0]  w_x, w_y;
  logic signed [EW-1:0]  w_ex, w_ey;
  logic signed [SQW-1:0] w_exw, w_eyw, w_sx_s, w_sy_s;
  logic [QW-1:0]         w_q;
  logic [DFW-1:0]        w_d_full;
  logic [DW-1:0]         w_d;
  logic [DW-1:0]         w_diff;
  logic [PRW-1:0]        w_prod;
  logic [7:0]            w_score;

  logic [4:0]            r_vld;
  logic [23:0]           r_pix [5];
  logic signed [8:0]     r_s1_dx, r_s1_dy;
  logic signed [PW-1:0]  r_s2_p1, r_s2_p2, r_s2_p3, r_s2_p4;
  logic signed [EW-1:0]  r_s3_ex, r_s3_ey;
  logic [SQW-1:0]        r_s4_sx, r_s4_sy;
  logic [QW-1:0]         r_s5_q;

  assign w_en         = !dataout_valid | dataout_ready;
  assign datain_ready = w_en;
  assign w_unused     = ^datain[7:0];

  assign w_dx = $signed({1'b0, datain[15:8]})  - $signed({1'b0, L_CX});
  assign w_dy = $signed({1'b0, datain[23:16]}) - $signed({1'b0, L_CY});

  assign w_p1 = PW'(r_s1_dx) * PW'(L_COS);
  assign w_p2 = PW'(r_s1_dy) * PW'(L_SIN);
  assign w_p3 = PW'(r_s1_dy) * PW'(L_COS);
  assign w_p4 = PW'(r_s1_dx) * PW'(L_SIN);

  // Dropping the low FRAC_W bits of a two's-complement sum is a floor shift.
  assign w_sum_x = SW'(r_s2_p1) + SW'(r_s2_p2);
  assign w_sum_y = SW'(r_s2_p3) - SW'(r_s2_p4);
  assign w_x     = w_sum_x[SW-1:FRAC_W];
  assign w_y     = w_sum_y[SW-1:FRAC_W];
  assign w_ex    = EW'(w_x) - L_ECX;
  assign w_ey    = EW'(w_y) - L_ECY;

  assign w_exw  = SQW'(r_s3_ex);
  assign w_eyw  = SQW'(r_s3_ey);
  assign w_sx_s = w_exw * w_exw;
  assign w_sy_s = w_eyw * w_eyw;

  assign w_q = QW'(r_s4_sx) * QW'(L_INV_A2) + QW'(r_s4_sy) * QW'(L_INV_B2);

  assign w_d_full = r_s5_q[QW-1:FRAC_W];
  assign w_d      = (w_d_full > L_DMAX_W) ? {DW{1'b1}} : w_d_full[DW-1:0];
  assign w_diff   = L_ONE - w_d;
  assign w_prod   = PRW'(w_diff) * PRW'(8'd255);

  // Final score from the saturated distance.
  always_comb begin
    w_score = 8'h00;
    if (MODE == 1) begin
      if (32'(w_d) < L_THRESH) w_score = 8'hFF;
      else                     w_score = 8'h00;
    end else begin
      if (w_d >= L_ONE) w_score = 8'h00;
      else              w_score = w_prod[FRAC_W+7:FRAC_W];
    end
  end

  // Pipeline registers; every stage advances together on w_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld         <= 5'b00000;
      dataout_valid <= 1'b0;
      dataout       <= 32'h0000_0000;
      for (int i = 0; i < 5; i++) r_pix[i] <= 24'h00_0000;
      r_s1_dx <= 9'sd0;
      r_s1_dy <= 9'sd0;
      r_s2_p1 <= PW'(0);
      r_s2_p2 <= PW'(0);
      r_s2_p3 <= PW'(0);
      r_s2_p4 <= PW'(0);
      r_s3_ex <= EW'(0);
      r_s3_ey <= EW'(0);
      r_s4_sx <= SQW'(0);
      r_s4_sy <= SQW'(0);
      r_s5_q  <= QW'(0);
    end else if (w_en) begin
      r_vld         <= {r_vld[3:0], datain_valid};
      dataout_valid <= r_vld[4];
      r_pix[0]      <= datain[31:8];
      for (int i = 1; i < 5; i++) r_pix[i] <= r_pix[i-1];
      dataout <= {r_pix[4], w_score};
      r_s1_dx <= w_dx;
      r_s1_dy <= w_dy;
      r_s2_p1 <= w_p1;
      r_s2_p2 <= w_p2;
      r_s2_p3 <= w_p3;
      r_s2_p4 <= w_p4;
      r_s3_ex <= w_ex;
      r_s3_ey <= w_ey;
      r_s4_sx <= w_sx_s;
      r_s4_sy <= w_sy_s;
      r_s5_q  <= w_q;
    end
  end

  // Skin-pixel counter; clear wins over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skin_count <= CNT_W'(0);
    end else if (count_clr) begin
      skin_count <= CNT_W'(0);
    end else if (dataout_valid && dataout_ready && (dataout[7:0] != 8'h00)) begin
      skin_count <= skin_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_skintone_ellipse_pipe.sv
// Bench for skintone_ellipse_pipe: a graded instance and a mask instance with a 4-bit
// counter share one stream; a queue-based arithmetic model checks every output handshake.
module tb_skintone_ellipse_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [31:0] din = 32'h0;
  logic        dout_ready = 1'b1;
  logic        count_clr = 1'b0;
  logic        dr0, dv0, dr1, dv1;
  logic [31:0] dout0, dout1, cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  skintone_ellipse_pipe u_dut (
    .clk(clk), .rst(rst), .datain_valid(din_valid), .datain(din), .datain_ready(dr0),
    .dataout_valid(dv0), .dataout(dout0), .dataout_ready(dout_ready),
    .count_clr(count_clr), .skin_count(cnt0));

  skintone_ellipse_pipe #(.MODE(1), .CNT_W(4)) u_m1 (
    .clk(clk), .rst(rst), .datain_valid(din_valid), .datain(din), .datain_ready(dr1),
    .dataout_valid(dv1), .dataout(dout1), .dataout_ready(dout_ready),
    .count_clr(count_clr), .skin_count(cnt1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Straight arithmetic from the ellipse definition with the default parameters.
  function automatic logic [7:0] f_score(input int cb, input int cr, input int mode);
    int dx, dy, x, y, ex, ey;
    longint q, d;
    dx = cb - 109;
    dy = cr - 152;
    x  = (dx * 511 + dy * 22) >>> 9;
    y  = (dy * 511 - dx * 22) >>> 9;
    ex = x - 2;
    ey = y - 2;
    q  = longint'(ex * ex) * 407 + longint'(ey * ey) * 1332;
    d  = q / 512;
    if (d > 2047) d = 2047;
    if (mode == 1) return (d < 256) ? 8'hFF : 8'h00;
    if (d >= 512) return 8'h00;
    return 8'(((512 - d) * 255) / 512);
  endfunction

  typedef struct { logic [31:0] d0; logic [31:0] d1; } exp_t;
  exp_t        expq[$];
  logic [31:0] exp_cnt0 = 32'h0;
  logic [3:0]  exp_cnt1 = 4'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d0 = 32'h0, prev_d1 = 32'h0;

  // Model-side compare, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expq.delete();
      exp_cnt0   = 32'h0;
      exp_cnt1   = 4'h0;
      prev_stall = 1'b0;
    end else begin
      check("ready0", 32'(dr0), 32'(!dv0 | dout_ready));
      check("ready1", 32'(dr1), 32'(!dv1 | dout_ready));
      if (prev_stall) begin
        check("hold_valid", 32'(dv0 & dv1), 32'h1);
        check("hold_data0", dout0, prev_d0);
        check("hold_data1", dout1, prev_d1);
      end
      check("count0", cnt0, exp_cnt0);
      check("count1", 32'(cnt1), 32'(exp_cnt1));
      if (dv0 && dout_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_output", dout0, 32'hxxxxxxxx);
        end else begin
          e = expq.pop_front();
          check("data0", dout0, e.d0);
          check("data1", dout1, e.d1);
          if (e.d0[7:0] != 8'h00) exp_cnt0 = exp_cnt0 + 32'd1;
          if (e.d1[7:0] != 8'h00) exp_cnt1 = exp_cnt1 + 4'd1;
        end
      end
      if (count_clr) begin
        exp_cnt0 = 32'h0;
        exp_cnt1 = 4'h0;
      end
      prev_stall = dv0 & !dout_ready;
      prev_d0    = dout0;
      prev_d1    = dout1;
      if (din_valid && dr0) begin
        e.d0 = {din[31:8], f_score(int'(din[15:8]), int'(din[23:16]), 0)};
        e.d1 = {din[31:8], f_score(int'(din[15:8]), int'(din[23:16]), 1)};
        expq.push_back(e);
      end
    end
  end

  task automatic push_px(input logic [31:0] px);
    int n = 0;
    din = px;
    din_valid = 1'b1;
    @(negedge clk);
    while (!dr0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!dv0 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 50) check("output_timeout", 32'(n), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    dout_ready = 1'b1;
    while ((expq.size() != 0 || dv0) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 200) check("drain_timeout", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ghost;
    logic [31:0] c0_save;
    logic [3:0]  c1_save;
    logic        done;

    // Reset state
    #1;
    check("rst_valid", 32'(dv0), 32'h0);
    check("rst_data", dout0, 32'h0);
    check("rst_count0", cnt0, 32'h0);
    check("rst_count1", 32'(cnt1), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Centre pixel: exact latency and known scores in both modes
    din = {8'd80, 8'd152, 8'd109, 8'hAA};
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    n = 1;
    while (!dv0 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", 32'(n), 32'd6);
    check("centre_mode0", dout0, 32'h50986DF8);
    check("centre_mode1", dout1, 32'h50986DFF);
    drain();
    check("centre_count0", cnt0, 32'd1);
    check("centre_count1", 32'(cnt1), 32'd1);

    // Far-off pixel: zero score, count untouched
    c0_save = cnt0;
    c1_save = cnt1;
    push_px({8'd80, 8'd0, 8'd0, 8'h00});
    wait_out();
    check("far_mode0", dout0, 32'h50000000);
    check("far_mode1", dout1, 32'h50000000);
    drain();
    check("far_count0", cnt0, c0_save);
    check("far_count1", 32'(cnt1), 32'(c1_save));

    // 20-pixel burst with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 20; i++) push_px({8'(i * 7), 8'(140 + i), 8'(100 + i), 8'h00});
      end
      begin
        repeat (10) @(posedge clk);
        #1 dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_ready", 32'(dr0), 32'h0);
        end
        @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    join
    drain();
    check("burst_empty", 32'(expq.size()), 32'd0);

    // Random gaps on both sides
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [7:0] cb, cr;
          cb = ($urandom_range(0, 1) == 1) ? 8'(69 + $urandom_range(0, 80)) : 8'($urandom_range(0, 255));
          cr = ($urandom_range(0, 1) == 1) ? 8'(112 + $urandom_range(0, 80)) : 8'($urandom_range(0, 255));
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
          end
          push_px({8'($urandom_range(0, 255)), cr, cb, 8'($urandom_range(0, 255))});
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 dout_ready = ($urandom_range(0, 3) != 0);
        end
        dout_ready = 1'b1;
      end
    join
    drain();
    check("random_empty", 32'(expq.size()), 32'd0);

    // Narrow counter wraps; clear beats a counted handshake
    count_clr = 1'b1;
    @(posedge clk);
    #1 count_clr = 1'b0;
    check("clr_count0", cnt0, 32'd0);
    for (int i = 0; i < 17; i++) push_px({8'd80, 8'd152, 8'd109, 8'h00});
    drain();
    check("wrap_count0", cnt0, 32'd17);
    check("wrap_count1", 32'(cnt1), 32'd1);
    dout_ready = 1'b0;
    push_px({8'd81, 8'd152, 8'd109, 8'h00});
    wait_out();
    count_clr = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1 count_clr = 1'b0;
    check("clr_win_count0", cnt0, 32'd0);
    check("clr_win_count1", 32'(cnt1), 32'd0);

    // Asynchronous reset with pixels in flight
    push_px({8'd82, 8'd152, 8'd109, 8'h00});
    drain();
    check("pre_rst_count0", cnt0, 32'd1);
    for (int i = 0; i < 4; i++) push_px({8'(90 + i), 8'd150, 8'd110, 8'h00});
    #2 rst = 1'b1;
    #1;
    check("async_valid", 32'(dv0), 32'h0);
    check("async_data", dout0, 32'h0);
    check("async_count0", cnt0, 32'h0);
    check("async_count1", 32'(cnt1), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    ghost = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (dv0 || dv1) ghost++;
    end
    check("no_ghost", 32'(ghost), 32'd0);
    check("final_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
